// File: rtl/cfg_lock_sequencer.sv
// -----------------------------------------------------------------------------
// cfg_lock_sequencer
//
// Boot-time initiator for a bank of lockable configuration registers. It takes
// NUM_REGS words from the host configuration stream and writes them to the
// bank. It then reads each register back and compares it with a shadow copy.
// Finally it pulses Lock once, whether or not the readback matched.
//
// Ports
//   Clk        in   clock, rising edge
//   resetn     in   asynchronous active-low reset
//   start      in   one-cycle request to begin a programming sequence
//   cfg_valid  in   host word valid
//   cfg_data   in   host configuration word
//   cfg_ready  out  word accepted this cycle when cfg_valid is also high
//   wr_addr    out  register index of the current write (registered)
//   wr_data    out  data of the current write (registered)
//   write      out  one-cycle write strobe, cycle after each handshake
//   Lock       out  one-cycle lock request after verification
//   rd_addr    out  readback index (combinational from the index counter)
//   rd_data    in   combinational readback of register rd_addr
//   busy       out  sequence in progress (LOAD through LOCK)
//   done       out  sequence complete, sticky until reset
//   error      out  readback mismatch seen, sticky until reset
// -----------------------------------------------------------------------------
module cfg_lock_sequencer #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2
) (
    input  logic              Clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              cfg_valid,
    input  logic [DATA_W-1:0] cfg_data,
    output logic              cfg_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              write,
    output logic              Lock,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_VERIFY = 3'd3,
        ST_LOCK   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]   shadow_q [NUM_REGS];
    logic                write_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic                error_q, error_d;

    logic                accept;
    logic                verify_cycle;
    logic [NUM_REGS-1:0] hit;
    logic [DATA_W-1:0]   shadow_sel;

    // One-hot decode of the index counter, shared by the shadow write port
    // and the readback compare mux.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_hit
        assign hit[gi] = (idx_q == ADDR_W'(gi));
    end

    always_comb begin
        shadow_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (hit[i]) begin
                shadow_sel = shadow_q[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cfg_ready    = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        Lock         = 1'b0;
        rd_addr      = '0;
        verify_cycle = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                end
            end
            ST_LOAD: begin
                cfg_ready = 1'b1;
                busy      = 1'b1;
                // No timeout: a silent host simply holds the sequencer here.
                if (cfg_valid) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_SETTLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            ST_SETTLE: begin
                // The last registered write is in flight this cycle; reading
                // it back any earlier would see the old register value.
                busy    = 1'b1;
                state_d = ST_VERIFY;
            end
            ST_VERIFY: begin
                busy         = 1'b1;
                rd_addr      = idx_q;
                verify_cycle = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_LOCK;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            ST_LOCK: begin
                // Lock is issued unconditionally so the bank is never left
                // writable, even after a failed readback.
                busy    = 1'b1;
                Lock    = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign accept  = cfg_valid & cfg_ready;
    assign error_d = error_q | (verify_cycle & (rd_data != shadow_sel));

    // ------------------------------------------------------------------
    // State, index, sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            error_q <= error_d;
        end
    end

    // ------------------------------------------------------------------
    // Shadow copy of every accepted word, used as the readback reference
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (accept && hit[i]) begin
                    shadow_q[i] <= cfg_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered write port: one strobe in the cycle after each handshake.
    // Address and data hold their last value between strobes.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            write_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            write_q <= accept;
            if (accept) begin
                wr_addr_q <= idx_q;
                wr_data_q <= cfg_data;
            end
        end
    end

    assign write   = write_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign error   = error_q;

endmodule

// File: tb/tb_cfg_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cfg_lock_sequencer
//
// Self-checking bench for cfg_lock_sequencer. The bench models the register
// bank: it updates on write and reads back combinationally, with optional
// corruption of one address. It derives every expected per-cycle trace from
// the sequencer's timing rules. Cycle 0 is the cycle in which start is driven.
// An accept happens in each cycle c >= 1 where the host presents a word. Write
// pulses follow each accept by one cycle. With A as the last accept cycle,
// Lock is at A+N+2 and done starts at A+N+3.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cfg_lock_sequencer;

    localparam int NR   = 4;
    localparam int LOGN = 64;

    logic        Clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [15:0] cfg_data = 16'h0;
    logic        cfg_ready;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic        write;
    logic        Lock;
    logic [1:0]  rd_addr;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
    logic        error;

    cfg_lock_sequencer #(.DATA_W(16), .NUM_REGS(NR), .ADDR_W(2)) dut (
        .Clk(Clk), .resetn(resetn), .start(start),
        .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .write(write), .Lock(Lock),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .error(error)
    );

    always #5 Clk = ~Clk;

    // ---------------- bank model ----------------
    logic [15:0] bank [NR];
    logic        corrupt_en = 1'b0;
    logic [1:0]  corrupt_addr = 2'd0;

    always @(posedge Clk) begin
        if (write) bank[wr_addr] <= wr_data;
    end
    assign rd_data = (corrupt_en && rd_addr == corrupt_addr) ? 16'hDEAD : bank[rd_addr];

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int base = 0;
    bit rec_en = 0;
    int lock_cnt = 0, write_cnt = 0, both_cnt = 0;
    int mon_r;

    logic        l_write [LOGN], l_lock [LOGN], l_busy [LOGN], l_done [LOGN];
    logic        l_err [LOGN], l_ready [LOGN];
    logic [1:0]  l_waddr [LOGN];
    logic [15:0] l_wdata [LOGN];

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        mon_r = cyc - base;
        if (rec_en && mon_r >= 0 && mon_r < LOGN) begin
            l_write[mon_r] = write;
            l_lock[mon_r]  = Lock;
            l_busy[mon_r]  = busy;
            l_done[mon_r]  = done;
            l_err[mon_r]   = error;
            l_ready[mon_r] = cfg_ready;
            l_waddr[mon_r] = wr_addr;
            l_wdata[mon_r] = wr_data;
        end
        if (write && Lock) both_cnt = both_cnt + 1;
        if (Lock) lock_cnt = lock_cnt + 1;
        if (write) write_cnt = write_cnt + 1;
    end

    // ---------------- stimulus + reference model ----------------
    logic [15:0] words [NR];
    bit          vpat [LOGN];
    bit          e_write [LOGN], e_lock [LOGN], e_busy [LOGN], e_done [LOGN];
    bit          e_err [LOGN], e_ready [LOGN];
    logic [1:0]  e_waddr [LOGN];
    logic [15:0] e_wdata [LOGN];
    int          m_A;

    task automatic build_model(output int total);
        int  acc [NR];
        int  n;
        bit  err_exp;
        n = 0;
        for (int i = 0; i < NR; i++) acc[i] = 0;
        for (int c = 1; c < LOGN && n < NR; c++) begin
            if (vpat[c]) begin
                acc[n] = c;
                n++;
            end
        end
        m_A = acc[NR-1];
        err_exp = corrupt_en && (words[corrupt_addr] != 16'hDEAD);
        for (int c = 0; c < LOGN; c++) begin
            e_ready[c] = (c >= 1 && c <= m_A);
            e_write[c] = 0;
            e_waddr[c] = 2'd0;
            e_wdata[c] = 16'h0;
            for (int i = 0; i < NR; i++) begin
                if (acc[i] + 1 == c) begin
                    e_write[c] = 1;
                    e_waddr[c] = 2'(i);
                    e_wdata[c] = words[i];
                end
            end
            e_lock[c] = (c == m_A + NR + 2);
            e_busy[c] = (c >= 1 && c <= m_A + NR + 2);
            e_done[c] = (c >= m_A + NR + 3);
            e_err[c]  = err_exp && (c >= m_A + 3 + int'(corrupt_addr));
        end
        total = m_A + NR + 6;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        start = 1'b0;
        cfg_valid = 1'b0;
        corrupt_en = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        resetn = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    // Drives one sequence from the current cycle (cycle 0 = start).
    task automatic run_seq(input int extra_start, input int total);
        int sent;
        sent = 0;
        base = cyc;
        rec_en = 1;
        for (int c = 0; c < total; c++) begin
            start = (c == 0) || (c == extra_start);
            if (c >= 1 && sent < NR && vpat[c]) begin
                cfg_valid = 1'b1;
                cfg_data  = words[sent];
                sent++;
            end else begin
                cfg_valid = 1'b0;
                cfg_data  = 16'($urandom);
            end
            @(posedge Clk);
            #1;
        end
        rec_en = 0;
        start = 1'b0;
        cfg_valid = 1'b0;
        $display("seq: words %h %h %h %h last_accept=%0d cycles=%0d", words[0], words[1], words[2], words[3], m_A, total);
    endtask

    task automatic set_nominal_words();
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
        for (int c = 0; c < LOGN; c++) vpat[c] = (c >= 1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0;
        #3;
        checks++;
        if ({cfg_ready, write, Lock, busy, done, error} !== 6'b0 || wr_addr !== 2'd0 || wr_data !== 16'h0 || rd_addr !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs got ready%0b w%0b L%0b b%0b d%0b e%0b wa%0d wd%h ra%0d expected all zero",
                     cfg_ready, write, Lock, busy, done, error, wr_addr, wr_data, rd_addr);
        end
        apply_reset();
        checks++;
        if ({cfg_ready, busy, done, error, Lock, write} !== 6'b0) begin
            errors++;
            $display("FAIL idle_after_reset got ready%0b b%0b d%0b e%0b L%0b w%0b expected all zero",
                     cfg_ready, busy, done, error, Lock, write);
        end
    endtask

    task automatic test_nominal();
        int total, l0, b0, first_lock, first_done;
        apply_reset();
        set_nominal_words();
        build_model(total);
        l0 = lock_cnt; b0 = both_cnt;
        run_seq(-1, total);
        first_lock = -1; first_done = -1;
        for (int c = 0; c < total; c++) begin
            if (l_lock[c] === 1'b1 && first_lock < 0) first_lock = c;
            if (l_done[c] === 1'b1 && first_done < 0) first_done = c;
            checks++;
            if (l_write[c] !== e_write[c] || l_lock[c] !== e_lock[c] || l_busy[c] !== e_busy[c] ||
                l_done[c] !== e_done[c] || l_ready[c] !== e_ready[c] || l_err[c] !== e_err[c]) begin
                errors++;
                $display("FAIL nominal_trace c=%0d got w%0b L%0b b%0b d%0b r%0b e%0b expected w%0b L%0b b%0b d%0b r%0b e%0b",
                         c, l_write[c], l_lock[c], l_busy[c], l_done[c], l_ready[c], l_err[c],
                         e_write[c], e_lock[c], e_busy[c], e_done[c], e_ready[c], e_err[c]);
            end
            if (e_write[c]) begin
                checks++;
                if (l_waddr[c] !== e_waddr[c] || l_wdata[c] !== e_wdata[c]) begin
                    errors++;
                    $display("FAIL nominal_write c=%0d got addr %0d data %h expected addr %0d data %h",
                             c, l_waddr[c], l_wdata[c], e_waddr[c], e_wdata[c]);
                end
            end
        end
        checks++;
        if (first_lock != 10 || first_done != 11) begin
            errors++;
            $display("FAIL nominal_lock_done got lock %0d done %0d expected lock 10 done 11", first_lock, first_done);
        end
        checks++;
        if (lock_cnt - l0 != 1 || both_cnt - b0 != 0) begin
            errors++;
            $display("FAIL nominal_exclusive got locks %0d overlaps %0d expected 1 and 0", lock_cnt - l0, both_cnt - b0);
        end
    endtask

    task automatic test_stall();
        int total, l0, b0, w0;
        apply_reset();
        set_nominal_words();
        for (int c = 3; c <= 7; c++) vpat[c] = 0;
        build_model(total);
        l0 = lock_cnt; b0 = both_cnt; w0 = write_cnt;
        run_seq(-1, total);
        for (int c = 0; c < total; c++) begin
            checks++;
            if (l_write[c] !== e_write[c] || l_ready[c] !== e_ready[c] || l_lock[c] !== e_lock[c] || l_done[c] !== e_done[c] ||
                (e_write[c] && (l_waddr[c] !== e_waddr[c] || l_wdata[c] !== e_wdata[c]))) begin
                errors++;
                $display("FAIL stall_trace c=%0d got w%0b r%0b L%0b d%0b a%0d %h expected w%0b r%0b L%0b d%0b a%0d %h",
                         c, l_write[c], l_ready[c], l_lock[c], l_done[c], l_waddr[c], l_wdata[c],
                         e_write[c], e_ready[c], e_lock[c], e_done[c], e_waddr[c], e_wdata[c]);
            end
        end
        checks++;
        if (l_lock[15] !== 1'b1 || lock_cnt - l0 != 1 || write_cnt - w0 != NR || both_cnt - b0 != 0 || l_err[total-1] !== 1'b0) begin
            errors++;
            $display("FAIL stall_summary got lock15 %0b locks %0d writes %0d overlaps %0d err %0b expected 1 1 4 0 0",
                     l_lock[15], lock_cnt - l0, write_cnt - w0, both_cnt - b0, l_err[total-1]);
        end
    endtask

    task automatic test_corrupt();
        int total, l0, b0;
        apply_reset();
        set_nominal_words();
        corrupt_en = 1'b1;
        corrupt_addr = 2'd2;
        build_model(total);
        l0 = lock_cnt; b0 = both_cnt;
        run_seq(-1, total);
        for (int c = 0; c < total; c++) begin
            checks++;
            if (l_err[c] !== e_err[c] || l_lock[c] !== e_lock[c] || l_done[c] !== e_done[c]) begin
                errors++;
                $display("FAIL corrupt_trace c=%0d got e%0b L%0b d%0b expected e%0b L%0b d%0b",
                         c, l_err[c], l_lock[c], l_done[c], e_err[c], e_lock[c], e_done[c]);
            end
        end
        checks++;
        if (error !== 1'b1 || done !== 1'b1 || lock_cnt - l0 != 1 || both_cnt - b0 != 0) begin
            errors++;
            $display("FAIL corrupt_summary got error %0b done %0b locks %0d overlaps %0d expected 1 1 1 0",
                     error, done, lock_cnt - l0, both_cnt - b0);
        end
        corrupt_en = 1'b0;
    endtask

    task automatic test_ignored_start();
        int total, l0, b0, w0;
        apply_reset();
        set_nominal_words();
        build_model(total);
        l0 = lock_cnt; b0 = both_cnt; w0 = write_cnt;
        run_seq(2, total);
        for (int c = 0; c < total; c++) begin
            checks++;
            if (l_write[c] !== e_write[c] || l_lock[c] !== e_lock[c] || l_busy[c] !== e_busy[c]) begin
                errors++;
                $display("FAIL ignored_start_trace c=%0d got w%0b L%0b b%0b expected w%0b L%0b b%0b",
                         c, l_write[c], l_lock[c], l_busy[c], e_write[c], e_lock[c], e_busy[c]);
            end
        end
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        repeat (6) @(posedge Clk);
        #1;
        checks++;
        if (lock_cnt - l0 != 1 || write_cnt - w0 != NR || both_cnt - b0 != 0 || done !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start_summary got locks %0d writes %0d overlaps %0d done %0b busy %0b ready %0b expected 1 4 0 1 0 0",
                     lock_cnt - l0, write_cnt - w0, both_cnt - b0, done, busy, cfg_ready);
        end
    endtask

    task automatic test_reset_mid();
        int total, l0, b0;
        apply_reset();
        set_nominal_words();
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        cfg_valid = 1'b1; cfg_data = words[0];
        @(posedge Clk); #1;
        cfg_data = words[1];
        @(posedge Clk); #1;
        cfg_valid = 1'b0;
        checks++;
        if (write !== 1'b1 || wr_addr !== 2'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre got write %0b addr %0d busy %0b expected 1 1 1", write, wr_addr, busy);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({cfg_ready, write, Lock, busy, done, error} !== 6'b0 || wr_addr !== 2'd0 || wr_data !== 16'h0 || rd_addr !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs got ready%0b w%0b L%0b b%0b d%0b e%0b wa%0d wd%h ra%0d expected all zero",
                     cfg_ready, write, Lock, busy, done, error, wr_addr, wr_data, rd_addr);
        end
        @(negedge Clk);
        resetn = 1'b1;
        @(posedge Clk); #1;
        for (int i = 0; i < NR; i++) words[i] = 16'($urandom);
        build_model(total);
        l0 = lock_cnt; b0 = both_cnt;
        run_seq(-1, total);
        for (int c = 0; c < total; c++) begin
            if (e_write[c] || l_write[c] === 1'b1) begin
                checks++;
                if (l_write[c] !== e_write[c] || l_waddr[c] !== e_waddr[c] || l_wdata[c] !== e_wdata[c]) begin
                    errors++;
                    $display("FAIL reset_mid_write c=%0d got w%0b a%0d %h expected w%0b a%0d %h",
                             c, l_write[c], l_waddr[c], l_wdata[c], e_write[c], e_waddr[c], e_wdata[c]);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || lock_cnt - l0 != 1 || both_cnt - b0 != 0 ||
            bank[0] !== words[0] || bank[1] !== words[1] || bank[2] !== words[2] || bank[3] !== words[3]) begin
            errors++;
            $display("FAIL reset_mid_summary got done %0b error %0b locks %0d overlaps %0d bank %h %h %h %h expected 1 0 1 0 %h %h %h %h",
                     done, error, lock_cnt - l0, both_cnt - b0, bank[0], bank[1], bank[2], bank[3],
                     words[0], words[1], words[2], words[3]);
        end
    endtask

    task automatic test_random();
        int total, l0, b0;
        for (int it = 0; it < 8; it++) begin
            apply_reset();
            for (int i = 0; i < NR; i++) words[i] = 16'($urandom);
            for (int c = 0; c < LOGN; c++) vpat[c] = (c >= 1) && (c > 16 || $urandom_range(0, 2) != 0);
            corrupt_en   = 1'($urandom_range(0, 1));
            corrupt_addr = 2'($urandom_range(0, NR - 1));
            build_model(total);
            l0 = lock_cnt; b0 = both_cnt;
            run_seq(-1, total);
            for (int c = 0; c < total; c++) begin
                checks++;
                if (l_write[c] !== e_write[c] || l_lock[c] !== e_lock[c] || l_busy[c] !== e_busy[c] ||
                    l_done[c] !== e_done[c] || l_ready[c] !== e_ready[c] || l_err[c] !== e_err[c] ||
                    (e_write[c] && (l_waddr[c] !== e_waddr[c] || l_wdata[c] !== e_wdata[c]))) begin
                    errors++;
                    $display("FAIL random_trace it=%0d c=%0d got w%0b L%0b b%0b d%0b r%0b e%0b a%0d %h expected w%0b L%0b b%0b d%0b r%0b e%0b a%0d %h",
                             it, c, l_write[c], l_lock[c], l_busy[c], l_done[c], l_ready[c], l_err[c], l_waddr[c], l_wdata[c],
                             e_write[c], e_lock[c], e_busy[c], e_done[c], e_ready[c], e_err[c], e_waddr[c], e_wdata[c]);
                end
            end
            checks++;
            if (lock_cnt - l0 != 1 || both_cnt - b0 != 0) begin
                errors++;
                $display("FAIL random_exclusive it=%0d got locks %0d overlaps %0d expected 1 and 0", it, lock_cnt - l0, both_cnt - b0);
            end
            corrupt_en = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_stall();
        test_corrupt();
        test_ignored_start();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfg_lock_sequencer.md
# cfg_lock_sequencer

Boot-time initiator that programs a bank of lockable configuration registers, reads each one back to verify it, then locks the bank. It sits between the host configuration stream and the write/Lock side of the protected register bank. It is the only agent that issues writes to the bank during boot. It never drives or depends on any debug-unlock path.

## Interface
Parameters:
- DATA_W, 16, width of each configuration word
- NUM_REGS, 4, number of registers in the target bank (≥2)
- ADDR_W, 2, register address width (≥ clog2(NUM_REGS))

Ports:
- Clk  in  1  clock, all logic on rising edge
- resetn  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to begin a programming sequence
- cfg_valid  in  1  host word valid
- cfg_data  in  DATA_W  host configuration word
- cfg_ready  out  1  sequencer accepts a word this cycle
- wr_addr  out  ADDR_W  target register index for the current write
- wr_data  out  DATA_W  data driven to the target register input
- write  out  1  one-cycle write strobe to the target bank
- Lock  out  1  one-cycle lock request to the target bank
- rd_addr  out  ADDR_W  readback index
- rd_data  in  DATA_W  combinational readback of register rd_addr
- busy  out  1  sequence in progress
- done  out  1  sequence complete (sticky until reset)
- error  out  1  readback mismatch seen (sticky until reset)

## Operation
- States: IDLE, LOAD, SETTLE, VERIFY, LOCK, DONE.
- IDLE: cfg_ready=0, busy=0. start=1 → LOAD, idx=0.
- LOAD: cfg_ready=1. Handshake is cfg_valid & cfg_ready. On each handshake:
  - cfg_data is stored in shadow[idx].
  - Next cycle: write=1, wr_addr=idx, wr_data=cfg_data, all registered.
  - idx increments.
- LOAD: cfg_valid low stalls indefinitely; there is no timeout. After the handshake with idx=NUM_REGS-1 → SETTLE, idx=0.
- SETTLE: one cycle, so that the final write lands in the bank.
- VERIFY: rd_addr=idx combinationally from the index counter. Each cycle, rd_data is compared with shadow[idx] and idx increments.
  - A mismatch sets error; verification continues.
  - After idx=NUM_REGS-1 → LOCK.
- LOCK: Lock=1 for exactly one cycle, even when error=1. The bank is never left unlocked. Then → DONE.
- DONE: done=1, busy=0. Terminal until reset; start is ignored.
- start is ignored while busy.
- idx counter is ADDR_W bits and never wraps past NUM_REGS-1.
- write and Lock are never high in the same cycle.
- Reset (asynchronous, any state, including mid-LOAD or mid-VERIFY):
  - state=IDLE, idx=0, shadow cleared.
  - All outputs 0: cfg_ready, write, Lock, busy, done, error, wr_addr, wr_data, rd_addr.

## Timing
- busy=1 from the cycle after start is sampled, through the LOCK cycle.
- Write latency: write is asserted in the cycle after each accepted handshake.
- cfg_ready drops in the cycle after the final handshake.
- Verify reads require the bank to update on the edge where write=1 is sampled, with rd_data combinational.
- With cfg_valid held high and start sampled in cycle 0:
  - accepts in cycles 1..N
  - write pulses in cycles 2..N+1
  - SETTLE in cycle N+1
  - VERIFY in cycles N+2..2N+1
  - Lock in cycle 2N+2
  - done=1 from cycle 2N+3
- For N=4: Lock in cycle 10, done in cycle 11.
- error is set in the cycle after the failing compare cycle.

## Test plan
- Nominal: start, stream 0x1111, 0x2222, 0x3333, 0x4444 with valid held high → four write pulses at addresses 0..3 with matching data; Lock in cycle 10; done=1 and error=0 from cycle 11.
- Stalled host: drop cfg_valid for 5 cycles after the second word → cfg_ready stays 1; no write strobes during the stall; sequence completes 5 cycles later with correct data.
- Readback corruption: bench forces register 2 to read 0xDEAD instead of 0x3333 → error=1; Lock still pulses once; done=1.
- Ignored requests: start pulsed during LOAD and again in DONE → no restart, no extra write or Lock pulses.
- Reset mid-operation: assert resetn low after the second accept → all outputs 0 immediately. After release and a new start, the full sequence reprograms all four registers from index 0.
- Exclusivity checks, applied to every test: write and Lock are never both high; exactly one Lock pulse per completed sequence.
